demux1to4_skid: RTL and testbench
=================================

// Module: demux1to4_skid
// PURPOSE
//  Inverse of the 4:1 result mux: steers one ready/valid stream to one of four
//  ready/valid consumers, selected per transfer by a 2-bit tag.
//  A 2-entry skid buffer registers the path with no combinational
//  i_ready->o_ready path. It sustains 1 transfer/cycle and keeps global FIFO order.
//  Used between the shared pipeline back-end and per-unit/per-thread consumers.
// PARAMETERS
//  DEMUX_DATA_WIDTH  32  payload width in bits
// PORTS
//  clk       in   1     clock; all state updates on rising edge
//  reset     in   1     asynchronous, active-high reset
//  i_flush   in   1     synchronous flush; discards all buffered entries
//  i_valid   in   1     upstream transfer valid
//  o_ready   out  1     upstream ready; transfer fires when i_valid & o_ready
//  i_sel     in   2     destination channel of the input transfer (0..3)
//  i_data    in   DEMUX_DATA_WIDTH  input payload
//  o_valid   out  4     one-hot (or zero) per-channel valid
//  i_ready   in   4     per-channel downstream ready
//  o_data    out  DEMUX_DATA_WIDTH  payload, shared by all four channels
// BEHAVIOUR
//  Storage: main {sel,data} feeds the outputs; skid {sel,data} holds overflow.
//  FSM on a registered state: EMPTY (none valid), HALF (main), FULL (main+skid).
//  in_fire  = i_valid & o_ready;  out_fire = (state!=EMPTY) & i_ready[main_sel].
//  o_ready  = (state != FULL); decoded from state only, no comb input paths.
//  o_valid[k] = (state!=EMPTY) & (main_sel==k); at most one bit set.
//  Transitions (when i_flush=0):
//   EMPTY: in_fire -> HALF, main<=in.
//   HALF : in&out -> HALF, main<=in; in&!out -> FULL, skid<=in;
//          !in&out -> EMPTY; neither -> hold.
//   FULL : out_fire -> HALF, main<=skid; else hold. No input is accepted.
//  Latency: accepted input appears on o_valid on the next cycle.
//  Throughput: 1 transfer/cycle while the target channel's ready is high.
//  Ordering: strict FIFO across channels. A stalled head blocks later transfers,
//   even when those transfers target other, ready channels.
//  Stability: while o_valid[k]=1 and i_ready[k]=0, o_data and o_valid stay constant.
//  i_ready of unselected channels is ignored and must not change state.
//  o_data is don't-care when o_valid=0 and holds the last main value.
//  i_flush=1: the next state is EMPTY and no input is captured. o_ready stays
//   per the current state, so an upstream "fire" that cycle is dropped.
//   Flush wins over simultaneous in_fire and out_fire.
//  Reset (any time, incl. mid-transfer): state=EMPTY, main/skid sel and data=0.
//   Outputs: o_valid=4'b0000, o_ready=1, o_data=0.
//   Buffered entries are lost; no partial transfer is emitted.
// TESTING
//  1 reset: assert reset mid-FULL -> o_valid=0, o_ready=1, o_data=0 at once.
//  2 streaming: sel 0,1,2,3 with data A0..A3, all i_ready=1 -> one o_valid per
//    cycle, 4'b0001..4'b1000, data A0..A3 in order, 1-cycle latency.
//  3 backpressure: i_ready=0, push sel=2 D=0x11, then sel=1 D=0x22.
//    Expect FULL and o_ready=0; o_valid=4'b0100 with 0x11 held.
//    Set i_ready[2]=1 -> 0x11 out, then o_valid=4'b0010 with 0x22.
//  4 head-of-line: head sel=3 stalled with i_ready=4'b0111 -> sel=0 entry
//    not emitted until i_ready[3]=1; order 3 then 0.
//  5 simultaneous in/out in HALF with target ready -> stays HALF, no bubble.
//    In FULL with i_valid=1 -> input not accepted until state drops to HALF.
//  6 flush: FULL with i_flush=1 and i_valid=1 -> next cycle EMPTY, o_valid=0.
//    That input is never delivered.

Source files
------------

// File: rtl/demux1to4_skid.sv
// demux1to4_skid: steers one ready/valid stream to one of four consumers by a 2-bit tag,
// through a 2-entry registered skid buffer that preserves global FIFO order.
module demux1to4_skid #(
    parameter int DEMUX_DATA_WIDTH = 32
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        i_flush,
    input  logic                        i_valid,
    output logic                        o_ready,
    input  logic [1:0]                  i_sel,
    input  logic [DEMUX_DATA_WIDTH-1:0] i_data,
    output logic [3:0]                  o_valid,
    input  logic [3:0]                  i_ready,
    output logic [DEMUX_DATA_WIDTH-1:0] o_data
);

    localparam logic [1:0] ST_EMPTY = 2'd0;
    localparam logic [1:0] ST_HALF  = 2'd1;
    localparam logic [1:0] ST_FULL  = 2'd2;

    logic [1:0]                  r_state;
    logic [1:0]                  w_state_nxt;
    logic [1:0]                  r_main_sel;
    logic [DEMUX_DATA_WIDTH-1:0] r_main_data;
    logic [1:0]                  r_skid_sel;
    logic [DEMUX_DATA_WIDTH-1:0] r_skid_data;

    logic w_in_fire;
    logic w_out_fire;
    logic w_main_from_in;
    logic w_main_from_skid;
    logic w_skid_from_in;

    // Handshake outputs come from registered state only, so i_ready never reaches o_ready.
    assign o_ready    = (r_state != ST_FULL);
    assign o_data     = r_main_data;
    assign w_in_fire  = i_valid & o_ready;
    assign w_out_fire = (r_state != ST_EMPTY) & i_ready[r_main_sel];

    always_comb begin
        o_valid = '0;
        if (r_state != ST_EMPTY) begin
            o_valid[r_main_sel] = 1'b1;
        end
    end

    always_comb begin
        w_state_nxt      = r_state;
        w_main_from_in   = 1'b0;
        w_main_from_skid = 1'b0;
        w_skid_from_in   = 1'b0;
        if (i_flush) begin
            w_state_nxt = ST_EMPTY;
        end else begin
            case (r_state)
                ST_EMPTY: begin
                    if (w_in_fire) begin
                        w_state_nxt    = ST_HALF;
                        w_main_from_in = 1'b1;
                    end
                end
                ST_HALF: begin
                    if (w_in_fire && w_out_fire) begin
                        w_main_from_in = 1'b1;
                    end else if (w_in_fire) begin
                        w_state_nxt    = ST_FULL;
                        w_skid_from_in = 1'b1;
                    end else if (w_out_fire) begin
                        w_state_nxt = ST_EMPTY;
                    end
                end
                ST_FULL: begin
                    if (w_out_fire) begin
                        w_state_nxt      = ST_HALF;
                        w_main_from_skid = 1'b1;
                    end
                end
                default: w_state_nxt = ST_EMPTY;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= ST_EMPTY;
            r_main_sel  <= '0;
            r_main_data <= '0;
            r_skid_sel  <= '0;
            r_skid_data <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_main_from_in) begin
                r_main_sel  <= i_sel;
                r_main_data <= i_data;
            end else if (w_main_from_skid) begin
                r_main_sel  <= r_skid_sel;
                r_main_data <= r_skid_data;
            end
            if (w_skid_from_in) begin
                r_skid_sel  <= i_sel;
                r_skid_data <= i_data;
            end
        end
    end

endmodule

// File: tb/tb_demux1to4_skid.sv
// Self-checking bench for demux1to4_skid: vector table plus FIFO scoreboard
// checked every cycle, and hand-written sequences for multi-cycle corners.
module tb_demux1to4_skid;

    logic        clk = 1'b0;
    logic        reset;
    logic        i_flush;
    logic        i_valid;
    logic        o_ready;
    logic [1:0]  i_sel;
    logic [31:0] i_data;
    logic [3:0]  o_valid;
    logic [3:0]  i_ready;
    logic [31:0] o_data;

    int checks = 0;
    int failures = 0;

    typedef struct {
        logic [1:0]  sel;
        logic [31:0] data;
    } ent_t;

    typedef struct {
        logic        v;
        logic [1:0]  s;
        logic [31:0] d;
        logic [3:0]  r;
        logic        f;
        logic [3:0]  exp_ov;
        logic        exp_ordy;
        logic [31:0] exp_od;
    } vec_t;

    ent_t        q[$];
    logic [31:0] m_last = '0;

    demux1to4_skid #(.DEMUX_DATA_WIDTH(32)) dut (
        .clk     (clk),
        .reset   (reset),
        .i_flush (i_flush),
        .i_valid (i_valid),
        .o_ready (o_ready),
        .i_sel   (i_sel),
        .i_data  (i_data),
        .o_valid (o_valid),
        .i_ready (i_ready),
        .o_data  (o_data)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Compare outputs against the scoreboard head, apply inputs for one cycle,
    // then advance the reference FIFO. Called and returns at a falling edge.
    task automatic step(input logic v, input logic [1:0] s, input logic [31:0] d,
                        input logic [3:0] r, input logic f);
        logic inf;
        logic outf;
        logic [3:0] eov;
        i_valid = v;
        i_sel   = s;
        i_data  = d;
        i_ready = r;
        i_flush = f;
        eov = '0;
        if (q.size() > 0) eov[q[0].sel] = 1'b1;
        chk("sb_o_valid", {28'd0, o_valid}, {28'd0, eov});
        chk("sb_o_ready", {31'd0, o_ready}, {31'd0, (q.size() < 2)});
        chk("sb_o_data", o_data, (q.size() > 0) ? q[0].data : m_last);
        inf  = v && (q.size() < 2);
        outf = (q.size() > 0) && r[q[0].sel];
        @(posedge clk);
        if (f) begin
            q.delete();
        end else begin
            if (outf) void'(q.pop_front());
            if (inf) q.push_back('{sel: s, data: d});
        end
        if (q.size() > 0) m_last = q[0].data;
        @(negedge clk);
    endtask

    task automatic idle(input logic [3:0] r);
        step(1'b0, 2'd0, 32'h0, r, 1'b0);
    endtask

    vec_t tbl[13];

    initial begin
        reset   = 1'b1;
        i_flush = 1'b0;
        i_valid = 1'b0;
        i_sel   = '0;
        i_data  = '0;
        i_ready = '0;

        // streaming: sel 0..3, all ready; then backpressure with unselected ready ignored
        tbl[0]  = '{1'b1, 2'd0, 32'hA000_0000, 4'hF, 1'b0, 4'b0000, 1'b1, 32'h0};
        tbl[1]  = '{1'b1, 2'd1, 32'hA000_0001, 4'hF, 1'b0, 4'b0001, 1'b1, 32'hA000_0000};
        tbl[2]  = '{1'b1, 2'd2, 32'hA000_0002, 4'hF, 1'b0, 4'b0010, 1'b1, 32'hA000_0001};
        tbl[3]  = '{1'b1, 2'd3, 32'hA000_0003, 4'hF, 1'b0, 4'b0100, 1'b1, 32'hA000_0002};
        tbl[4]  = '{1'b0, 2'd0, 32'h0,         4'hF, 1'b0, 4'b1000, 1'b1, 32'hA000_0003};
        tbl[5]  = '{1'b1, 2'd2, 32'h11,        4'h0, 1'b0, 4'b0000, 1'b1, 32'hA000_0003};
        tbl[6]  = '{1'b1, 2'd1, 32'h22,        4'h0, 1'b0, 4'b0100, 1'b1, 32'h11};
        tbl[7]  = '{1'b1, 2'd3, 32'h99,        4'hB, 1'b0, 4'b0100, 1'b0, 32'h11};
        tbl[8]  = '{1'b0, 2'd0, 32'h0,         4'hB, 1'b0, 4'b0100, 1'b0, 32'h11};
        tbl[9]  = '{1'b0, 2'd0, 32'h0,         4'h4, 1'b0, 4'b0100, 1'b0, 32'h11};
        tbl[10] = '{1'b0, 2'd0, 32'h0,         4'h0, 1'b0, 4'b0010, 1'b1, 32'h22};
        tbl[11] = '{1'b0, 2'd0, 32'h0,         4'h2, 1'b0, 4'b0010, 1'b1, 32'h22};
        tbl[12] = '{1'b0, 2'd0, 32'h0,         4'h0, 1'b0, 4'b0000, 1'b1, 32'h22};

        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;

        for (int i = 0; i < 13; i++) begin
            chk($sformatf("tbl%0d_o_valid", i), {28'd0, o_valid}, {28'd0, tbl[i].exp_ov});
            chk($sformatf("tbl%0d_o_ready", i), {31'd0, o_ready}, {31'd0, tbl[i].exp_ordy});
            chk($sformatf("tbl%0d_o_data", i), o_data, tbl[i].exp_od);
            step(tbl[i].v, tbl[i].s, tbl[i].d, tbl[i].r, tbl[i].f);
        end

        // head-of-line: stalled sel=3 head blocks a ready sel=0 entry
        step(1'b1, 2'd3, 32'h33, 4'b0111, 1'b0);
        step(1'b1, 2'd0, 32'h44, 4'b0111, 1'b0);
        idle(4'b0111);
        chk("hol_stalled_valid", {28'd0, o_valid}, 32'h8);
        chk("hol_stalled_data", o_data, 32'h33);
        idle(4'b1111);
        chk("hol_second_valid", {28'd0, o_valid}, 32'h1);
        chk("hol_second_data", o_data, 32'h44);
        idle(4'b1111);

        // simultaneous in/out in HALF: no bubble
        step(1'b1, 2'd1, 32'h51, 4'hF, 1'b0);
        step(1'b1, 2'd2, 32'h52, 4'hF, 1'b0);
        chk("nobubble_valid", {28'd0, o_valid}, 32'h4);
        chk("nobubble_ready", {31'd0, o_ready}, 32'h1);
        step(1'b1, 2'd0, 32'h53, 4'hF, 1'b0);
        idle(4'hF);

        // FULL holds off a valid input until it drops to HALF
        step(1'b1, 2'd0, 32'h61, 4'h0, 1'b0);
        step(1'b1, 2'd1, 32'h62, 4'h0, 1'b0);
        step(1'b1, 2'd2, 32'h63, 4'h0, 1'b0);
        step(1'b1, 2'd2, 32'h63, 4'h1, 1'b0);
        chk("full_drop_ready", {31'd0, o_ready}, 32'h1);
        step(1'b1, 2'd2, 32'h63, 4'h0, 1'b0);
        chk("full_refill_ready", {31'd0, o_ready}, 32'h0);
        idle(4'hF);
        idle(4'hF);
        idle(4'hF);

        // flush in FULL with valid input: nothing survives
        step(1'b1, 2'd0, 32'h71, 4'h0, 1'b0);
        step(1'b1, 2'd1, 32'h72, 4'h0, 1'b0);
        step(1'b1, 2'd3, 32'h77, 4'h0, 1'b1);
        chk("flush_full_valid", {28'd0, o_valid}, 32'h0);
        chk("flush_full_ready", {31'd0, o_ready}, 32'h1);
        idle(4'hF);
        // flush in HALF with a firing input: input not captured
        step(1'b1, 2'd2, 32'h81, 4'h0, 1'b0);
        step(1'b1, 2'd3, 32'h82, 4'hF, 1'b1);
        chk("flush_half_valid", {28'd0, o_valid}, 32'h0);
        idle(4'hF);

        // random traffic against the scoreboard
        for (int i = 0; i < 300; i++) begin
            step(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), $urandom,
                 4'($urandom_range(0, 15)), ($urandom_range(0, 19) == 0));
        end

        // asynchronous reset asserted mid-FULL
        step(1'b1, 2'd1, 32'h91, 4'h0, 1'b0);
        step(1'b1, 2'd2, 32'h92, 4'h0, 1'b0);
        step(1'b1, 2'd2, 32'h93, 4'h0, 1'b0);
        chk("pre_reset_full", {31'd0, o_ready}, 32'h0);
        i_valid = 1'b0;
        #2 reset = 1'b1;
        #1;
        chk("reset_o_valid", {28'd0, o_valid}, 32'h0);
        chk("reset_o_ready", {31'd0, o_ready}, 32'h1);
        chk("reset_o_data", o_data, 32'h0);
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        q.delete();
        m_last = '0;
        idle(4'hF);
        step(1'b1, 2'd3, 32'hB3, 4'hF, 1'b0);
        idle(4'hF);
        idle(4'hF);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
